// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: three 1-entry holding buffers (MEM, ALU, MD) share one register-file write port.
// Optional macro STARVE_GUARD_EN adds per-source age counters that promote long-waiting entries.
module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int AGE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [1:0]        grant_src,
    output logic              busy
);

    // Index 0 = MEM, 1 = ALU, 2 = MD
    logic [2:0]        in_valid;
    logic [2:0]        full;
    logic [2:0]        gnt;
    logic [2:0]        ready;
    logic [ADDR_W-1:0] in_reg   [3];
    logic [DATA_W-1:0] in_data  [3];
    logic [ADDR_W-1:0] buf_reg  [3];
    logic [DATA_W-1:0] buf_data [3];

    logic              any_gnt;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_src;

    assign in_valid   = {md_valid, alu_valid, mem_valid};
    assign in_reg[0]  = mem_reg;
    assign in_reg[1]  = alu_reg;
    assign in_reg[2]  = md_reg;
    assign in_data[0] = mem_data;
    assign in_data[1] = alu_data;
    assign in_data[2] = md_data;

    assign ready     = ~full | gnt;
    assign mem_ready = ready[0];
    assign alu_ready = ready[1];
    assign md_ready  = ready[2];
    assign busy      = |full;

`ifdef STARVE_GUARD_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age [3];
    logic [2:0]       aged;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            aged[i] = full[i] && (age[i] == AGE_W'(AGE_LIMIT));
        end
    end

    // Aged entries reverse the normal order so the slowest source recovers first
    always_comb begin
        gnt = 3'b000;
        if (aged[2])      gnt = 3'b100;
        else if (aged[1]) gnt = 3'b010;
        else if (aged[0]) gnt = 3'b001;
        else if (full[0]) gnt = 3'b001;
        else if (full[1]) gnt = 3'b010;
        else if (full[2]) gnt = 3'b100;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || !full[i] || gnt[i]) begin
                age[i] <= '0;
            end else if (age[i] != AGE_W'(AGE_LIMIT)) begin
                age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    logic unused_age_limit;
    assign unused_age_limit = |AGE_LIMIT;

    always_comb begin
        gnt = 3'b000;
        if (full[0])      gnt = 3'b001;
        else if (full[1]) gnt = 3'b010;
        else if (full[2]) gnt = 3'b100;
    end
`endif

    always_comb begin
        any_gnt  = |gnt;
        sel_reg  = '0;
        sel_data = '0;
        sel_src  = 2'd0;
        if (gnt[0]) begin
            sel_reg  = buf_reg[0];
            sel_data = buf_data[0];
            sel_src  = 2'd1;
        end else if (gnt[1]) begin
            sel_reg  = buf_reg[1];
            sel_data = buf_data[1];
            sel_src  = 2'd2;
        end else if (gnt[2]) begin
            sel_reg  = buf_reg[2];
            sel_data = buf_data[2];
            sel_src  = 2'd3;
        end
    end

    // Writes to r0 are consumed but never buffered
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                full[i] <= 1'b0;
            end else if (in_valid[i] && ready[i] && (in_reg[i] != '0)) begin
                full[i] <= 1'b1;
            end else if (gnt[i]) begin
                full[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (in_valid[i] && ready[i] && (in_reg[i] != '0)) begin
                buf_reg[i]  <= in_reg[i];
                buf_data[i] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_src  <= 2'd0;
        end else begin
            RegWrite  <= any_gnt;
            grant_src <= sel_src;
            if (any_gnt) begin
                write_reg  <= sel_reg;
                write_data <= sel_data;
            end
        end
    end

endmodule
